// File: rtl/ram_burst_reader_if.sv
// Write port, burst request and streamed-word handshake of the burst reader.
// master drives writes/requests and out_ready; slave is the RAM/reader side.
interface ram_burst_reader_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_start;
   logic [ADDR_W-1:0] rd_base;
   logic [ADDR_W:0]   rd_len;
   logic              rd_busy;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_last;
   logic              rd_done;

   modport master (
      output wr_en, wr_addr, wr_data, rd_start, rd_base, rd_len, out_ready,
      input  rd_busy, out_valid, out_data, out_addr, out_last, rd_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_start, rd_base, rd_len, out_ready,
      output rd_busy, out_valid, out_data, out_addr, out_last, rd_done
   );
endinterface

// File: rtl/ram_burst_reader.sv
// Register RAM with a burst streamer; first word valid 1 cycle after an accepted start.
// out_ready low stalls the burst with data/addr/last held; 1 word/cycle when ready stays high.
module ram_burst_reader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input logic               clk,
   input logic               rst_n,
   ram_burst_reader_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_TWO   = (ADDR_W+1)'(2);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t            state, state_n;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]   cnt, cnt_n, start_len;
   logic [DATA_W-1:0] data_q, data_n;
   logic [ADDR_W-1:0] addr_q, addr_n, load_addr;
   logic              valid_q, valid_n;
   logic              last_q, last_n;
   logic              busy_q, busy_n;
   logic              done_q, done_n;
   logic              load;

   // Oversized requests are clamped so no word is streamed twice.
   assign start_len = (bus.rd_len > DEPTH_LEN) ? DEPTH_LEN : bus.rd_len;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      valid_n   = valid_q;
      last_n    = last_q;
      busy_n    = busy_q;
      done_n    = done_q;
      load      = 1'b0;
      load_addr = addr_q;
      case (state)
         IDLE: begin
            if (bus.rd_start && (bus.rd_len != '0)) begin
               load      = 1'b1;
               load_addr = bus.rd_base;
               cnt_n     = start_len;
               last_n    = (start_len == CNT_ONE);
               valid_n   = 1'b1;
               busy_n    = 1'b1;
               state_n   = SEND;
            end
         end
         SEND: begin
            if (valid_q && bus.out_ready) begin
               if (cnt > CNT_ONE) begin
                  load      = 1'b1;
                  load_addr = addr_q + ADDR_ONE;
                  cnt_n     = cnt - CNT_ONE;
                  last_n    = (cnt == CNT_TWO);
               end else begin
                  valid_n = 1'b0;
                  last_n  = 1'b0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = DONE;
               end
            end
         end
         DONE: begin
            done_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // A write landing on the word being loaded this edge is forwarded.
      addr_n = addr_q;
      data_n = data_q;
      if (load) begin
         addr_n = load_addr;
         data_n = (bus.wr_en && (bus.wr_addr == load_addr)) ? bus.wr_data : mem[load_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         data_q  <= data_n;
         addr_q  <= addr_n;
         valid_q <= valid_n;
         last_q  <= last_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (bus.wr_en) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_addr  = addr_q;
   assign bus.out_last  = last_q;
   assign bus.rd_busy   = busy_q;
   assign bus.rd_done   = done_q;
endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader: stimulus pushes expected words, a negedge monitor checks them.
module tb_ram_burst_reader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ram_burst_reader_if #(.DATA_W(8), .ADDR_W(4)) bus_if ();

   ram_burst_reader #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   typedef struct {
      logic [7:0] d;
      logic [3:0] a;
      logic       l;
   } exp_t;

   exp_t       exp_q[$];
   bit         done_due = 1'b0;
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] model [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic [3:0] a, input logic l);
      exp_t e;
      e.d = d; e.a = a; e.l = l;
      exp_q.push_back(e);
   endtask

   task automatic push_model(input logic [3:0] b, input int len);
      int n;
      logic [3:0] a;
      n = (len > 16) ? 16 : len;
      for (int i = 0; i < n; i++) begin
         a = b + 4'(i);
         push(model[a], a, i == n - 1);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      bus_if.wr_en = 1'b1; bus_if.wr_addr = a; bus_if.wr_data = d;
      tick();
      bus_if.wr_en = 1'b0;
      model[a] = d;
   endtask

   task automatic start(input logic [3:0] b, input logic [4:0] len);
      bus_if.rd_start = 1'b1; bus_if.rd_base = b; bus_if.rd_len = len;
      tick();
      bus_if.rd_start = 1'b0;
   endtask

   task automatic drain(input bit toggle);
      int k = 0;
      while ((exp_q.size() != 0 || done_due) && k < 200) begin
         bus_if.out_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
         tick();
         k++;
      end
      check("drain within budget", 32'(k < 200), 1);
      bus_if.out_ready = 1'b1;
      tick();
      tick();
   endtask

   // Monitor: front of queue must match whenever valid; pop on handshake.
   always @(negedge clk) begin
      exp_t e;
      if (done_due) begin
         check("rd_done pulse after last", 32'(bus_if.rd_done), 1);
         check("rd_busy low with rd_done", 32'(bus_if.rd_busy), 0);
         done_due = 1'b0;
      end else begin
         check("rd_done idle", 32'(bus_if.rd_done), 0);
      end
      if (bus_if.out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected out_valid", 32'(bus_if.out_valid), 0);
         end else begin
            e = exp_q[0];
            check("out_data", 32'(bus_if.out_data), 32'(e.d));
            check("out_addr", 32'(bus_if.out_addr), 32'(e.a));
            check("out_last", 32'(bus_if.out_last), 32'(e.l));
            if (bus_if.out_ready) begin
               void'(exp_q.pop_front());
               if (e.l) done_due = 1'b1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus_if.wr_en = 1'b0; bus_if.wr_addr = '0; bus_if.wr_data = '0;
      bus_if.rd_start = 1'b0; bus_if.rd_base = '0; bus_if.rd_len = '0;
      bus_if.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      #12;
      check("reset out_valid", 32'(bus_if.out_valid), 0);
      check("reset rd_busy",   32'(bus_if.rd_busy), 0);
      check("reset out_data",  32'(bus_if.out_data), 0);
      check("reset out_addr",  32'(bus_if.out_addr), 0);
      check("reset out_last",  32'(bus_if.out_last), 0);
      check("reset rd_done",   32'(bus_if.rd_done), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // 1: base 3, len 4, ready held high.
      for (int i = 0; i < 16; i++) wr(4'(i), 8'(8'h10 + i));
      push(8'h13, 4'd3, 1'b0); push(8'h14, 4'd4, 1'b0);
      push(8'h15, 4'd5, 1'b0); push(8'h16, 4'd6, 1'b1);
      bus_if.out_ready = 1'b1;
      start(4'd3, 5'd4);
      check("t1 first valid latency", 32'(bus_if.out_valid), 1);
      check("t1 rd_busy after start", 32'(bus_if.rd_busy), 1);
      repeat (4) tick();
      check("t1 four words in four cycles", 32'(exp_q.size()), 0);
      check("t1 rd_done after last", 32'(bus_if.rd_done), 1);
      check("t1 out_valid low after last", 32'(bus_if.out_valid), 0);
      drain(1'b0);

      // 2: same burst with ready toggling.
      push(8'h13, 4'd3, 1'b0); push(8'h14, 4'd4, 1'b0);
      push(8'h15, 4'd5, 1'b0); push(8'h16, 4'd6, 1'b1);
      bus_if.out_ready = 1'b0;
      start(4'd3, 5'd4);
      drain(1'b1);

      // 3: wrap-around and length saturation.
      push(8'h1E, 4'd14, 1'b0); push(8'h1F, 4'd15, 1'b0);
      push(8'h10, 4'd0, 1'b0);  push(8'h11, 4'd1, 1'b1);
      start(4'd14, 5'd4);
      drain(1'b0);
      push_model(4'd14, 20);
      start(4'd14, 5'd20);
      drain(1'b1);

      // 4: zero-length start ignored; start mid-burst ignored.
      start(4'd2, 5'd0);
      for (int i = 0; i < 3; i++) begin
         check("t4 len0 no valid", 32'(bus_if.out_valid), 0);
         check("t4 len0 not busy", 32'(bus_if.rd_busy), 0);
         tick();
      end
      push(8'h13, 4'd3, 1'b0); push(8'h14, 4'd4, 1'b0);
      push(8'h15, 4'd5, 1'b0); push(8'h16, 4'd6, 1'b1);
      bus_if.out_ready = 1'b0;
      start(4'd3, 5'd4);
      tick();
      start(4'd9, 5'd2);
      drain(1'b1);
      repeat (3) tick();

      // 5: write to presented word is invisible; write to next word is forwarded.
      push(8'h15, 4'd5, 1'b0); push(8'h55, 4'd6, 1'b0); push(8'h17, 4'd7, 1'b1);
      bus_if.out_ready = 1'b0;
      start(4'd5, 5'd3);
      wr(4'd5, 8'hAA);
      bus_if.out_ready = 1'b1;
      wr(4'd6, 8'h55);
      drain(1'b0);

      // 6: reset mid-burst aborts and clears memory.
      push_model(4'd0, 8);
      bus_if.out_ready = 1'b1;
      start(4'd0, 5'd8);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("t6 reset out_valid", 32'(bus_if.out_valid), 0);
      check("t6 reset rd_busy",   32'(bus_if.rd_busy), 0);
      check("t6 reset out_data",  32'(bus_if.out_data), 0);
      check("t6 reset out_last",  32'(bus_if.out_last), 0);
      exp_q.delete();
      done_due = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      tick();
      rst_n = 1'b1;
      tick();
      push(8'h00, 4'd2, 1'b0); push(8'h00, 4'd3, 1'b0); push(8'h00, 4'd4, 1'b1);
      start(4'd2, 5'd3);
      drain(1'b0);
      wr(4'd4, 8'h3C);
      push(8'h3C, 4'd4, 1'b1);
      start(4'd4, 5'd1);
      drain(1'b1);
      check("final queue empty", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
